regfile_read_arbiter: RTL and testbench

- Shares one 16-entry x 32-bit register-file read port (a 16:1 read mux) among NREQ requesters.
- Requesters are e.g. decode operand A/B, store-data and debug.
- Arbitration is round-robin. The block drives the mux select, captures the mux output into a register and returns it to the winner with a valid/ready response handshake.
- Sits between pipeline-stage requesters and the register-file read mux.

---
 rtl/regfile_read_arbiter_if.sv | 45 ++++
 rtl/regfile_read_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regfile_read_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter_if
// Bundles the request, read-mux and response signals of regfile_read_arbiter.
//
//   req_valid [NREQ]      per-requester read request
//   req_addr  [NREQ*AW]   packed addresses, requester i at [i*AW +: AW]
//   req_ready [NREQ]      one-hot accept pulse (combinational)
//   mux_sel   [AW]        registered select into the register-file read mux
//   mux_data  [DW]        read mux output, combinational from mux_sel
//   rsp_valid             response data valid
//   rsp_data  [DW]        captured register value
//   rsp_id    [IDW]       requester that owns the response
//   rsp_ready             response consumer accepts
//   busy                  arbiter FSM is not idle
//
// slave  : arbiter side
// master : requesters, response consumer and read-mux side
// -----------------------------------------------------------------------------
interface regfile_read_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int AW   = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ-1:0]    req_ready;
   logic [AW-1:0]      mux_sel;
   logic [DW-1:0]      mux_data;
   logic               rsp_valid;
   logic [DW-1:0]      rsp_data;
   logic [IDW-1:0]     rsp_id;
   logic               rsp_ready;
   logic               busy;

   modport slave (
      input  req_valid, req_addr, mux_data, rsp_ready,
      output req_ready, mux_sel, rsp_valid, rsp_data, rsp_id, busy
   );

   modport master (
      output req_valid, req_addr, mux_data, rsp_ready,
      input  req_ready, mux_sel, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter
// Shares one register-file read port (16:1 read mux) among NREQ requesters.
// A winner is chosen in IDLE, its address is registered onto mux_sel, the mux
// output is captured one cycle later and returned with a valid/ready response.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous, active-high reset
//   bus    regfile_read_arbiter_if.slave (request, read mux, response, busy)
//
// Parameters: NREQ (2..8), DW, AW, IDW (2**IDW >= NREQ).
//
// Build option:
//   RFARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins, no
//                                     round-robin pointer.
//                        undefined -> round-robin (default).
// -----------------------------------------------------------------------------
module regfile_read_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int AW   = 4,
   parameter int IDW  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   regfile_read_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q;
   logic [AW-1:0]   mux_sel_q;
   logic            rsp_valid_q;
   logic [DW-1:0]   rsp_data_q;
   logic [IDW-1:0]  rsp_id_q;
   logic            busy_q;

   // Lowest-index valid requester; this is the whole decision in fixed
   // priority and the wrap-around half of the round-robin search.
   logic            found_lo;
   logic [IDW-1:0]  id_lo;
   logic [NREQ-1:0] oh_lo;

   logic            any_valid;
   logic [IDW-1:0]  win_id;
   logic [NREQ-1:0] win_oh;
   logic [AW-1:0]   win_addr;
   logic            accept;

   always_comb begin
      found_lo = 1'b0;
      id_lo    = '0;
      oh_lo    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found_lo && bus.req_valid[i]) begin
            found_lo = 1'b1;
            id_lo    = IDW'(i);
            oh_lo[i] = 1'b1;
         end
      end
   end

`ifdef RFARB_FIXED_PRIO_EN
   assign any_valid = found_lo;
   assign win_id    = id_lo;
   assign win_oh    = oh_lo;
`else
   // Round-robin pointer: index of the requester served most recently.
   logic [IDW-1:0]  last_q;
   logic            found_hi;
   logic [IDW-1:0]  id_hi;
   logic [NREQ-1:0] oh_hi;

   // Search above the pointer first; if nothing is valid there, the
   // lowest-index search provides the wrapped winner.
   always_comb begin
      found_hi = 1'b0;
      id_hi    = '0;
      oh_hi    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found_hi && bus.req_valid[i] && (i > int'(last_q))) begin
            found_hi = 1'b1;
            id_hi    = IDW'(i);
            oh_hi[i] = 1'b1;
         end
      end
   end

   assign any_valid = found_hi | found_lo;
   assign win_id    = found_hi ? id_hi : id_lo;
   assign win_oh    = found_hi ? oh_hi : oh_lo;
`endif

   // win_oh is one-hot (or zero), so OR-ing the masked fields selects one address.
   always_comb begin
      win_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            win_addr = win_addr | bus.req_addr[i*AW +: AW];
         end
      end
   end

   assign accept        = (state_q == IDLE) && any_valid && !reset;
   assign bus.req_ready = accept ? win_oh : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mux_sel_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         busy_q      <= 1'b0;
`ifndef RFARB_FIXED_PRIO_EN
         last_q      <= IDW'(NREQ - 1);
`endif
      end else begin
         case (state_q)
            // Grant: drive the winner's address into the read mux.
            IDLE: begin
               if (any_valid) begin
                  mux_sel_q <= win_addr;
                  rsp_id_q  <= win_id;
                  busy_q    <= 1'b1;
                  state_q   <= READ;
               end
            end
            // Mux output is settled from the registered select; capture it.
            READ: begin
               rsp_data_q  <= bus.mux_data;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            // Hold the response until the consumer takes it; the pointer
            // moves only here, on completion.
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
`ifndef RFARB_FIXED_PRIO_EN
                  last_q      <= rsp_id_q;
`endif
               end
            end
            default: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mux_sel   = mux_sel_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_arbiter
// Directed bench for regfile_read_arbiter. The register-file read mux is
// modelled as Q5 = 32'hDEAD_BEEF and Qn = n*32'h11 for every other address.
// -----------------------------------------------------------------------------
module tb_regfile_read_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int AW   = 4;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   regfile_read_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW), .IDW(IDW)) bus ();

   regfile_read_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .IDW(IDW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mux_data = (bus.mux_sel == 4'd5) ? 32'hDEAD_BEEF
                                               : (32'(bus.mux_sel) * 32'h11);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.rsp_ready = 1'b0;
      step();
      step();
      total++; if (bus.mux_sel !== 4'd0) begin bad++; $display("FAIL reset_mux_sel got=%0h exp=0", bus.mux_sel); end
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid); end
      total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data got=%0h exp=0", bus.rsp_data); end
      total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
      bus.req_valid = 4'b1111;
      #1;
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
      bus.req_valid = '0;
      reset         = 1'b0;
   endtask

   task automatic test_single();
      bus.req_valid = 4'b0001;
      bus.req_addr  = {4'd0, 4'd0, 4'd0, 4'd5};
      bus.rsp_ready = 1'b1;
      #1;
      total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_req_ready got=%b exp=0001", bus.req_ready); end
      step();
      bus.req_valid = '0;
      total++; if (bus.mux_sel !== 4'd5) begin bad++; $display("FAIL single_mux_sel got=%0d exp=5", bus.mux_sel); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_read got=%0b exp=1", bus.busy); end
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_valid_read got=%0b exp=0", bus.rsp_valid); end
      step();
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%0b exp=1", bus.rsp_valid); end
      total++; if (bus.rsp_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rsp_data got=%0h exp=deadbeef", bus.rsp_data); end
      total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL single_rsp_id got=%0d exp=0", bus.rsp_id); end
      step();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_done got=%0b exp=0", bus.busy); end
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_valid_done got=%0b exp=0", bus.rsp_valid); end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_id   [5];
      logic [31:0] exp_data [5];
      int          cnt;
`ifdef RFARB_FIXED_PRIO_EN
      exp_id   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      exp_data = '{32'h11, 32'h11, 32'h11, 32'h11, 32'h11};
`else
      exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_data = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11};
`endif
      reset = 1'b1;
      step();
      reset         = 1'b0;
      bus.req_valid = 4'b1111;
      bus.req_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cnt = 0;
         do begin
            step();
            cnt++;
         end while (!bus.rsp_valid && cnt < 12);
         total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_rsp_timeout resp=%0d got=%0b exp=1", k, bus.rsp_valid); end
         total++; if (bus.rsp_id !== exp_id[k]) begin bad++; $display("FAIL rr_rsp_id resp=%0d got=%0d exp=%0d", k, bus.rsp_id, exp_id[k]); end
         total++; if (bus.rsp_data !== exp_data[k]) begin bad++; $display("FAIL rr_rsp_data resp=%0d got=%0h exp=%0h", k, bus.rsp_data, exp_data[k]); end
         total++; if (cnt !== ((k == 0) ? 2 : 3)) begin bad++; $display("FAIL rr_spacing resp=%0d got=%0d exp=%0d", k, cnt, (k == 0) ? 2 : 3); end
      end
      bus.req_valid = '0;
      step();
   endtask

   task automatic test_backpressure();
      bus.req_valid = 4'b0010;
      bus.req_addr  = {4'd0, 4'd0, 4'd7, 4'd0};
      bus.rsp_ready = 1'b0;
      step();
      bus.req_valid = 4'b0100;
      bus.req_addr  = {4'd0, 4'd9, 4'd7, 4'd0};
      step();
      for (int i = 0; i < 5; i++) begin
         total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_valid cyc=%0d got=%0b exp=1", i, bus.rsp_valid); end
         total++; if (bus.rsp_data !== 32'h77) begin bad++; $display("FAIL bp_rsp_data cyc=%0d got=%0h exp=77", i, bus.rsp_data); end
         total++; if (bus.rsp_id !== 2'd1) begin bad++; $display("FAIL bp_rsp_id cyc=%0d got=%0d exp=1", i, bus.rsp_id); end
         total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0000", i, bus.req_ready); end
         step();
      end
      bus.rsp_ready = 1'b1;
      step();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_busy_idle got=%0b exp=0", bus.busy); end
      total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL bp_second_grant got=%b exp=0100", bus.req_ready); end
      step();
      bus.req_valid = '0;
      total++; if (bus.mux_sel !== 4'd9) begin bad++; $display("FAIL bp_second_mux_sel got=%0d exp=9", bus.mux_sel); end
      step();
      total++; if (bus.rsp_id !== 2'd2) begin bad++; $display("FAIL bp_second_rsp_id got=%0d exp=2", bus.rsp_id); end
      total++; if (bus.rsp_data !== 32'h99) begin bad++; $display("FAIL bp_second_rsp_data got=%0h exp=99", bus.rsp_data); end
      step();
   endtask

   task automatic test_reset_mid();
      bus.req_valid = 4'b0001;
      bus.req_addr  = {4'd0, 4'd0, 4'd0, 4'd5};
      bus.rsp_ready = 1'b0;
      step();
      bus.req_valid = '0;
      step();
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_rsp_valid got=%0b exp=1", bus.rsp_valid); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_valid got=%0b exp=0", bus.rsp_valid); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b exp=0", bus.busy); end
      total++; if (bus.mux_sel !== 4'd0) begin bad++; $display("FAIL mid_mux_sel got=%0d exp=0", bus.mux_sel); end
      total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL mid_rsp_data got=%0h exp=0", bus.rsp_data); end
      bus.req_valid = 4'b1100;
      bus.req_addr  = {4'd3, 4'd2, 4'd0, 4'd0};
      bus.rsp_ready = 1'b1;
      #1;
      total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL mid_next_grant got=%b exp=0100", bus.req_ready); end
      step();
      bus.req_valid = '0;
      total++; if (bus.mux_sel !== 4'd2) begin bad++; $display("FAIL mid_next_mux_sel got=%0d exp=2", bus.mux_sel); end
      step();
      total++; if (bus.rsp_id !== 2'd2) begin bad++; $display("FAIL mid_next_rsp_id got=%0d exp=2", bus.rsp_id); end
      total++; if (bus.rsp_data !== 32'h22) begin bad++; $display("FAIL mid_next_rsp_data got=%0h exp=22", bus.rsp_data); end
      step();
   endtask

   task automatic test_priority();
      logic [1:0]  exp_id   [4];
      logic [31:0] exp_data [4];
      int          cnt;
`ifdef RFARB_FIXED_PRIO_EN
      exp_id   = '{2'd1, 2'd1, 2'd1, 2'd1};
      exp_data = '{32'h11, 32'h11, 32'h11, 32'h11};
`else
      exp_id   = '{2'd1, 2'd3, 2'd1, 2'd3};
      exp_data = '{32'h11, 32'h33, 32'h11, 32'h33};
`endif
      reset = 1'b1;
      step();
      reset         = 1'b0;
      bus.req_valid = 4'b1010;
      bus.req_addr  = {4'd3, 4'd0, 4'd1, 4'd0};
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cnt = 0;
         do begin
            step();
            cnt++;
         end while (!bus.rsp_valid && cnt < 12);
         total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL prio_rsp_timeout resp=%0d got=%0b exp=1", k, bus.rsp_valid); end
         total++; if (bus.rsp_id !== exp_id[k]) begin bad++; $display("FAIL prio_rsp_id resp=%0d got=%0d exp=%0d", k, bus.rsp_id, exp_id[k]); end
         total++; if (bus.rsp_data !== exp_data[k]) begin bad++; $display("FAIL prio_rsp_data resp=%0d got=%0h exp=%0h", k, bus.rsp_data, exp_data[k]); end
      end
      bus.req_valid = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_priority();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
